reduce_sched: RTL and testbench

Scheduler for the reduction-instruction unit. Shares the single `reduce_instr` datapath between up to `NumReq` packet sources (local injection plus network input ports). It arbitrates round-robin, issues at most one 64-bit packet per cycle into the unit, and tracks the unit's fixed pipeline latency. Annotated 67-bit results (children count + packet) are buffered in an output FIFO with a valid/ready handshake toward the reduction table.

---
 rtl/reduce_sched_if.sv | 41 ++++
 rtl/reduce_sched.sv | 189 ++++++++++++++++++
 tb/tb_reduce_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reduce_sched_if.sv
// Bundle between reduce_sched and its requesters, the reduce_instr unit
// and the reduction-table consumer. Parameters must match the scheduler.
interface reduce_sched_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64,
    parameter int OutWidth  = 67
);
    logic [NumReq-1:0]           req_valid;
    logic [NumReq*DataWidth-1:0] req_data;
    logic [NumReq-1:0]           req_ready;
    logic [DataWidth-1:0]        instr_in;
    logic [OutWidth-1:0]         instr_out;
    logic                        out_valid;
    logic [OutWidth-1:0]         out_data;
    logic                        out_ready;
    logic [15:0]                 issued_count;

    modport slave (
        input  req_valid,
        input  req_data,
        input  instr_out,
        input  out_ready,
        output req_ready,
        output instr_in,
        output out_valid,
        output out_data,
        output issued_count
    );

    modport master (
        output req_valid,
        output req_data,
        output instr_out,
        output out_ready,
        input  req_ready,
        input  instr_in,
        input  out_valid,
        input  out_data,
        input  issued_count
    );
endinterface

// File: rtl/reduce_sched.sv
// Round-robin scheduler in front of the shared reduce_instr datapath.
// Define REDUCE_SCHED_PRIO_EN to give requester 0 strict priority.
module reduce_sched #(
    parameter int NumReq       = 4,
    parameter int DataWidth    = 64,
    parameter int OutWidth     = 67,
    parameter int InstrLatency = 1,
    parameter int FifoDepth    = 4
) (
    input logic          clk,
    input logic          rst,
    reduce_sched_if.slave bus
);
    localparam int IdxW = $clog2(NumReq);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    logic [IdxW-1:0]         r_rr_ptr;
    logic [InstrLatency-1:0] r_inflight;
    logic [15:0]             r_issued;
    logic [OutWidth-1:0]     r_mem [FifoDepth];
    logic [PtrW-1:0]         r_wr_ptr;
    logic [PtrW-1:0]         r_rd_ptr;
    logic [CntW-1:0]         r_count;
    state_t                  r_state;
    logic                    r_out_valid;

    logic [15:0]       w_infl_cnt;
    logic              w_can_issue;
    logic              w_hit;
    logic [IdxW-1:0]   w_gidx;
    logic [IdxW-1:0]   w_j;
    logic [NumReq-1:0] w_gnt;
    logic              w_issue;
    logic [IdxW-1:0]   w_rr_nxt;
    logic              w_push;
    logic              w_pop;

    always_comb begin
        w_infl_cnt = '0;
        for (int i = 0; i < InstrLatency; i++) begin
            w_infl_cnt = w_infl_cnt + 16'(r_inflight[i]);
        end
    end

    // A pop in this cycle does not free a credit until the next one.
    assign w_can_issue =
        (16'(r_count) + w_infl_cnt) < 16'(FifoDepth);

`ifdef REDUCE_SCHED_PRIO_EN
    int w_base;

    always_comb begin
        w_hit  = 1'b0;
        w_gidx = '0;
        w_j    = '0;
        w_base = (r_rr_ptr == '0) ? 0 : int'(r_rr_ptr) - 1;
        if (bus.req_valid[0]) begin
            w_hit = 1'b1;
        end
        for (int k = 0; k < NumReq - 1; k++) begin
            w_j = IdxW'(1 + (w_base + k) % (NumReq - 1));
            if (!w_hit && bus.req_valid[w_j]) begin
                w_hit  = 1'b1;
                w_gidx = w_j;
            end
        end
    end

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_issue && w_gidx != '0) begin
            w_rr_nxt = IdxW'((int'(w_gidx) + 1) % NumReq);
            if (w_rr_nxt == '0) begin
                w_rr_nxt = IdxW'(1);
            end
        end
    end
`else
    always_comb begin
        w_hit  = 1'b0;
        w_gidx = '0;
        w_j    = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_j = IdxW'((int'(r_rr_ptr) + k) % NumReq);
            if (!w_hit && bus.req_valid[w_j]) begin
                w_hit  = 1'b1;
                w_gidx = w_j;
            end
        end
    end

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_issue) begin
            w_rr_nxt = IdxW'((int'(w_gidx) + 1) % NumReq);
        end
    end
`endif

    always_comb begin
        w_gnt   = '0;
        w_issue = w_hit & w_can_issue & ~rst;
        if (w_issue) begin
            w_gnt[w_gidx] = 1'b1;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.instr_in  = w_issue ?
        bus.req_data[int'(w_gidx)*DataWidth +: DataWidth] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_inflight <= '0;
            r_issued   <= '0;
        end else begin
            r_rr_ptr   <= w_rr_nxt;
            r_inflight <= (r_inflight << 1) |
                          InstrLatency'(w_issue);
            if (w_issue) begin
                r_issued <= r_issued + 16'd1;
            end
        end
    end

    assign w_push = r_inflight[InstrLatency-1];
    assign w_pop  = r_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.instr_out;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
            unique case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_state     <= S_PARTIAL;
                        r_out_valid <= 1'b1;
                    end
                end
                S_PARTIAL: begin
                    if (w_push && !w_pop &&
                        r_count == CntW'(FifoDepth - 1)) begin
                        r_state <= S_FULL;
                    end else if (!w_push && w_pop &&
                                 r_count == CntW'(1)) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_pop && !w_push) begin
                        r_state <= S_PARTIAL;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_mem[r_rd_ptr];
    assign bus.issued_count = r_issued;
endmodule

// File: tb/tb_reduce_sched.sv
// Directed bench for reduce_sched with a one-cycle stand-in for reduce_instr.
// Stand-in annotates a packet as {pkt[2:0], pkt}.
module tb_reduce_sched;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int OW = 67;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reduce_sched_if #(
        .NumReq(N), .DataWidth(DW), .OutWidth(OW)
    ) bus ();

    reduce_sched #(
        .NumReq(N), .DataWidth(DW), .OutWidth(OW),
        .InstrLatency(1), .FifoDepth(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] dat [N] = '{
        64'h5,
        64'h1234_0000_0000_0011,
        64'hCAFE_0000_0000_0022,
        64'hFFFF_FFFF_FFFF_FF33
    };
    logic [DW-1:0] r_mock = '0;

    always @(posedge clk) r_mock <= bus.instr_in;
    assign bus.instr_out = {r_mock[2:0], r_mock};
    assign bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};

    function automatic logic [OW-1:0] ann(input int i);
        return {dat[i][2:0], dat[i]};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm,
                       input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    int sb_rr = 0;
    int occ   = 0;
    logic [OW-1:0] q [$];

    function automatic int exp_grant(input logic [3:0] v);
`ifdef REDUCE_SCHED_PRIO_EN
        int base;
        if (v[0]) return 0;
        base = (sb_rr == 0) ? 0 : sb_rr - 1;
        for (int k = 0; k < N - 1; k++) begin
            if (v[1 + (base + k) % (N - 1)])
                return 1 + (base + k) % (N - 1);
        end
`else
        for (int k = 0; k < N; k++) begin
            if (v[(sb_rr + k) % N]) return (sb_rr + k) % N;
        end
`endif
        return -1;
    endfunction

    // Called at the negedge: scores handshakes and pops.
    task automatic observe(input logic [3:0] v,
                           input logic ordy);
        int g;
        g = -1;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) g = i;
        end
        if (g >= 0) begin
            chk("grant_idx", OW'(g), OW'(exp_grant(v)));
            chk("instr_in", bus.instr_in, dat[g]);
            q.push_back(ann(g));
            occ++;
`ifdef REDUCE_SCHED_PRIO_EN
            if (g != 0) begin
                sb_rr = (g + 1) % N;
                if (sb_rr == 0) sb_rr = 1;
            end
`else
            sb_rr = (g + 1) % N;
`endif
        end else begin
            chk("instr_in_idle", bus.instr_in, '0);
        end
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h want none",
                         bus.out_data);
            end else begin
                chk("pop_data", bus.out_data, q.pop_front());
            end
            occ--;
        end
        chk("credit_bound", OW'(occ <= 4), OW'(1));
    endtask

    task automatic step(input logic [3:0] v, input logic ordy);
        bus.req_valid = v;
        bus.out_ready = ordy;
        @(negedge clk);
        observe(v, ordy);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        int          od;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv [$];

    task automatic add(input logic [3:0] v, input logic ordy,
                       input logic [3:0] rdy, input logic ov,
                       input int od, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.ordy = ordy; r.rdy = rdy;
        r.ov = ov; r.od = od; r.cnt = cnt;
        tv.push_back(r);
    endtask

    int hs;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, '0);
        chk("rst_instr_in", bus.instr_in, '0);
        chk("rst_out_valid", bus.out_valid, '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_count", bus.issued_count, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // od: -1 expects zero, -2 skips, else index of annotated head.
`ifdef REDUCE_SCHED_PRIO_EN
        add(4'hF, 1, 4'h1, 0, -1, 0);
        add(4'hF, 1, 4'h1, 0, -2, 1);
        add(4'hF, 1, 4'h1, 1,  0, 2);
        add(4'hE, 1, 4'h2, 1,  0, 3);
        add(4'hE, 1, 4'h4, 1,  0, 4);
        add(4'hE, 1, 4'h8, 1,  1, 5);
        add(4'hE, 1, 4'h2, 1,  2, 6);
        add(4'h0, 1, 4'h0, 1,  3, 7);
        add(4'h0, 1, 4'h0, 1,  1, 7);
        add(4'h0, 1, 4'h0, 0, -2, 7);
`else
        add(4'hF, 1, 4'h1, 0, -1, 0);
        add(4'hF, 1, 4'h2, 0, -2, 1);
        add(4'hF, 1, 4'h4, 1,  0, 2);
        add(4'hF, 1, 4'h8, 1,  1, 3);
        add(4'hF, 1, 4'h1, 1,  2, 4);
        add(4'hF, 1, 4'h2, 1,  3, 5);
        add(4'hF, 1, 4'h4, 1,  0, 6);
        add(4'hF, 1, 4'h8, 1,  1, 7);
        add(4'h0, 1, 4'h0, 1,  2, 8);
        add(4'h0, 1, 4'h0, 1,  3, 8);
        add(4'h0, 1, 4'h0, 0, -2, 8);
        add(4'h1, 1, 4'h1, 0, -2, 8);
        add(4'h0, 1, 4'h0, 0, -2, 9);
        add(4'h0, 1, 4'h0, 1,  0, 9);
        add(4'h0, 1, 4'h0, 0, -2, 9);
`endif

        for (int i = 0; i < tv.size(); i++) begin
            bus.req_valid = tv[i].v;
            bus.out_ready = tv[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), bus.req_ready, tv[i].rdy);
            chk($sformatf("v%0d_out_valid", i),
                bus.out_valid, tv[i].ov);
            if (tv[i].od == -1)
                chk($sformatf("v%0d_out_data", i), bus.out_data, '0);
            else if (tv[i].od >= 0)
                chk($sformatf("v%0d_out_data", i),
                    bus.out_data, ann(tv[i].od));
            chk($sformatf("v%0d_count", i),
                bus.issued_count, tv[i].cnt);
            observe(tv[i].v, tv[i].ordy);
            @(posedge clk);
            #1;
        end

        // Backpressure: credits allow exactly four handshakes.
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 4'hF;
            bus.out_ready = 1'b0;
            @(negedge clk);
            if (|bus.req_ready) hs++;
            observe(4'hF, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("bp_handshakes", OW'(hs), OW'(4));

        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_ready", bus.req_ready, '0);
        chk("bp_full_valid", bus.out_valid, 1'b1);
        observe(4'hF, 1'b1);
        @(posedge clk);
        #1;

        hs = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 4'hF;
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (|bus.req_ready) hs++;
            observe(4'hF, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("resume_handshakes", OW'(hs), OW'(10));

        for (int i = 0; i < 10; i++) step(4'h0, 1'b1);
        chk("drain_queue", OW'(q.size()), OW'(0));
        @(negedge clk);
        chk("drain_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Two buffered, one in flight, then reset.
        for (int i = 0; i < 3; i++) step(4'hF, 1'b0);
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("midrst_ready", bus.req_ready, '0);
        chk("midrst_instr_in", bus.instr_in, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        occ   = 0;
        sb_rr = 0;

        bus.req_valid = 4'hF;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", bus.out_valid, 1'b0);
        chk("post_rst_count", bus.issued_count, '0);
        chk("post_rst_grant", bus.req_ready, 4'h1);
        observe(4'hF, 1'b0);
        @(posedge clk);
        #1;

        bus.req_valid = 4'h0;
        @(negedge clk);
        chk("post_rst_stale", bus.out_valid, 1'b0);
        observe(4'h0, 1'b0);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_head_v", bus.out_valid, 1'b1);
        chk("post_rst_head_d", bus.out_data, ann(0));
        chk("post_rst_cnt1", bus.issued_count, 16'd1);
        observe(4'h0, 1'b1);
        @(posedge clk);
        #1;

        @(negedge clk);
        chk("post_rst_empty", bus.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
